// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared state encodings and command-byte defaults
// for the SPI mode-0 target port.
package spi_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_e;

    localparam logic [7:0] CMD_READ_DEF  = 8'h03;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage synchronizer for an asynchronous pin,
// plus single-cycle rise/fall pulses in the clk domain.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_target_port.sv
// spi_target_port: oversampled SPI mode-0 target giving an external
// master read/write access to a byte-wide memory via command/address frames.
module spi_target_port
    import spi_target_pkg::*;
#(
    parameter int         ADDR_W      = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_READ    = CMD_READ_DEF,
    parameter logic [7:0] CMD_WRITE   = CMD_WRITE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              frame_err
);

    state_e r_state;
    state_e w_next;

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_ss_rise;
    logic w_ss_fall;
    logic w_mosi;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_rx;
    logic [7:0]             r_tx;
    logic [7:0]             r_wdata;
    logic [ADDR_W-1:0]      r_addr;

    logic r_byte_done;
    logic r_end_pend;
    logic r_is_read;
    logic r_we;
    logic r_re;
    logic r_load;
    logic r_miso;
    logic r_ferr;

    logic w_active;
    logic w_last_rise;
    logic w_end;
    logic w_abort;
    logic w_we_set;
    logic w_re_set;
    logic w_addr_ld;
    logic w_addr_inc;
    logic w_cmd_ld;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
        .clk     (clk),
        .reset   (reset),
        .i_async (spi_clk),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
        .clk     (clk),
        .reset   (reset),
        .i_async (spi_ss),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    // Same depth as the edge detectors' level stage keeps mosi aligned to the rise pulse
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_active    = (r_state != ST_IDLE);
    assign w_last_rise = w_active && w_sck_rise && (r_bit_cnt == 3'd7);
    assign w_end       = w_active && w_ss_rise && !r_end_pend;
    assign w_abort     = (w_end && !w_last_rise) || r_end_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_we_set   = 1'b0;
        w_re_set   = 1'b0;
        w_addr_ld  = 1'b0;
        w_addr_inc = 1'b0;
        w_cmd_ld   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (r_byte_done) begin
                    w_cmd_ld = 1'b1;
                    if (r_rx == CMD_READ || r_rx == CMD_WRITE) begin
                        w_next = ST_ADDR;
                    end else begin
                        w_next = ST_IGNORE;
                    end
                end
            end
            ST_ADDR: begin
                if (r_byte_done) begin
                    w_addr_ld = 1'b1;
                    w_re_set  = r_is_read && !r_end_pend;
                    w_next    = r_is_read ? ST_RDATA : ST_WDATA;
                end
            end
            ST_WDATA: begin
                w_we_set = r_byte_done;
            end
            ST_RDATA: begin
                if (w_last_rise) begin
                    w_addr_inc = 1'b1;
                    w_re_set   = !w_end;
                end
            end
            ST_IGNORE: begin
                w_next = ST_IGNORE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // ss rise wins over a byte that completed earlier, but a byte
        // finishing on the same clk as ss rise is honoured first
        if (w_end && !w_last_rise) begin
            w_next     = ST_IDLE;
            w_we_set   = 1'b0;
            w_re_set   = 1'b0;
            w_addr_ld  = 1'b0;
            w_addr_inc = 1'b0;
            w_cmd_ld   = 1'b0;
        end else if (r_end_pend) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mosi_sync <= '0;
            r_bit_cnt   <= 3'd0;
            r_rx        <= 8'd0;
            r_tx        <= 8'd0;
            r_wdata     <= 8'd0;
            r_addr      <= '0;
            r_byte_done <= 1'b0;
            r_end_pend  <= 1'b0;
            r_is_read   <= 1'b0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_load      <= 1'b0;
            r_miso      <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_byte_done <= w_last_rise;
            r_end_pend  <= w_end && w_last_rise;
            r_ferr      <= w_end && !w_last_rise && (r_bit_cnt != 3'd0);

            if (w_abort || !w_active) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sck_rise) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_active && w_sck_rise) begin
                r_rx <= {r_rx[6:0], w_mosi};
            end

            if (w_cmd_ld) begin
                r_is_read <= (r_rx == CMD_READ);
            end

            if (w_addr_ld) begin
                r_addr <= ADDR_W'(r_rx);
            end else if (w_addr_inc || r_we) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            r_we <= w_we_set;
            if (w_we_set) begin
                r_wdata <= r_rx;
            end

            r_re   <= w_re_set;
            r_load <= r_re;
            if (r_load) begin
                r_tx <= mem_rdata;
            end else if (r_state == ST_RDATA && w_sck_fall) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end

            if (r_state != ST_RDATA) begin
                r_miso <= 1'b0;
            end else if (w_sck_fall) begin
                r_miso <= r_tx[7];
            end
        end
    end

    assign miso      = r_miso && (r_state == ST_RDATA);
    assign miso_oe   = w_active;
    assign busy      = w_active;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = r_we;
    assign mem_re    = r_re;
    assign frame_err = r_ferr;

endmodule
